// File: rtl/weights_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// weights_fetch_ctrl_pkg
//   Shared definitions for the weights fetch sequencer:
//   - fetch_state_e : 2-bit FSM encoding (IDLE / FETCH / DRAIN / DONE)
//   - word width helpers: one memory word packs three signed RGB weights
// ----------------------------------------------------------------------------
package weights_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    localparam int WEIGHTS_PER_WORD   = 3;
    localparam int DEFAULT_DATA_WIDTH = 5;
    localparam int DEFAULT_WORD_WIDTH = WEIGHTS_PER_WORD * DEFAULT_DATA_WIDTH;

    // Width of one packed memory word for a given per-weight width.
    function automatic int word_width(input int data_width);
        return WEIGHTS_PER_WORD * data_width;
    endfunction

endpackage

// File: rtl/weights_skid_fifo.sv
// ----------------------------------------------------------------------------
// weights_skid_fifo
//   Two-entry FIFO between the memory read return and the MAC interface.
//   The head entry is a dedicated register so the consumer-facing data and
//   valid come straight from flops; the second entry only fills when the
//   head is occupied and not leaving in the same cycle.
// Ports
//   clock, reset   : clock, asynchronous active-high reset
//   flush          : empty the FIFO next edge (wins over push)
//   push/push_data : write one entry (caller guarantees room)
//   pop            : consumer takes head this cycle (ignored when empty)
//   head_data      : current head entry
//   head_valid     : head entry is valid
//   count          : number of stored entries (0..2)
// ----------------------------------------------------------------------------
module weights_skid_fifo
    import weights_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_WIDTH + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             pop_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop & valid_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = push_data;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop_ok) begin
                        head_d = push_data;
                    end else if (push) begin
                        tail_d  = push_data;
                        count_d = 2'd2;
                    end else if (pop_ok) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    // Full: the issue gate never allows a push here without a pop.
                    if (pop_ok) begin
                        head_d = tail_q;
                        if (push) begin
                            tail_d = push_data;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end

        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/weights_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// weights_fetch_ctrl
//   Sequencer between the weights memory and the MAC datapath. A pass reads
//   NUM_WORDS consecutive words starting at BASE_ADDR, tracks the one-cycle
//   read latency and hands each word to the MAC through a 2-entry FIFO with a
//   valid/ready interface. Reads are throttled so that stored plus in-flight
//   words never exceed the FIFO depth, so backpressure never loses a word.
// Ports
//   clock, reset : clock, asynchronous active-high reset
//   start        : begin a pass (only looked at in IDLE)
//   abort        : cancel the pass, flush everything, back to IDLE
//   mem_addr     : read address; holds the last issued address when idle
//   mem_en_read  : read enable, data returns the following cycle
//   mem_data     : read data from memory
//   w_data/w_valid/w_ready/w_last : word stream to the MAC
//   busy         : pass in progress (FETCH or DRAIN)
//   done         : one-cycle pulse after the final word is accepted
// ----------------------------------------------------------------------------
module weights_fetch_ctrl
    import weights_fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_DEPTH = 12,
    parameter int NUM_WORDS  = 4096,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [ADDR_DEPTH-1:0]   mem_addr,
    output logic                    mem_en_read,
    input  logic [3*DATA_WIDTH-1:0] mem_data,
    output logic [3*DATA_WIDTH-1:0] w_data,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic                    w_last,
    output logic                    busy,
    output logic                    done
);

    localparam int WORD_W = word_width(DATA_WIDTH);
    // One extra bit so the index can reach NUM_WORDS itself without wrapping.
    localparam int CNT_W  = ADDR_DEPTH + 1;

    localparam logic [CNT_W-1:0]      NUM_WORDS_C = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0]      LAST_IDX_C  = CNT_W'(NUM_WORDS - 1);
    localparam logic [ADDR_DEPTH-1:0] BASE_C      = ADDR_DEPTH'(BASE_ADDR);

    fetch_state_e          state_q, state_d;
    logic [CNT_W-1:0]      addr_cnt_q, addr_cnt_d;
    logic [ADDR_DEPTH-1:0] last_addr_q, last_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  issue;
    logic                  fifo_flush;
    logic                  fifo_push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [ADDR_DEPTH-1:0] issue_addr;
    logic [WORD_W:0]       fifo_head;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;

    assign pop        = fifo_valid & w_ready;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue_addr = BASE_C + addr_cnt_q[ADDR_DEPTH-1:0];

    always_comb begin
        state_d         = state_q;
        addr_cnt_d      = addr_cnt_q;
        last_addr_d     = last_addr_q;
        inflight_last_d = inflight_last_q;
        issue           = 1'b0;
        fifo_flush      = 1'b0;

        if (abort) begin
            // Abort beats start and any pending issue; whatever is in flight
            // is dropped because inflight_d follows issue, which stays low.
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_FETCH;
                        addr_cnt_d = '0;
                    end
                end
                ST_FETCH: begin
                    // A pop this cycle frees a slot, which is what allows one
                    // read per cycle while the MAC keeps up.
                    if ((addr_cnt_q < NUM_WORDS_C) &&
                        (occupancy < (3'd2 + {2'b00, pop}))) begin
                        issue           = 1'b1;
                        addr_cnt_d      = addr_cnt_q + CNT_W'(1);
                        last_addr_d     = issue_addr;
                        inflight_last_d = (addr_cnt_q == LAST_IDX_C);
                        if (addr_cnt_q == LAST_IDX_C) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[WORD_W]) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        inflight_d = issue;
        busy_d     = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    // Memory data is only captured in the cycle after a read was issued.
    assign fifo_push = inflight_q & ~fifo_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_cnt_q      <= '0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_cnt_q      <= addr_cnt_d;
            last_addr_q     <= last_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    weights_skid_fifo #(
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_data  ({inflight_last_q, mem_data}),
        .pop        (pop),
        .head_data  (fifo_head),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    // The read enable must see this cycle's pop to sustain full throughput,
    // so it is the live issue decision; the address shows the word being
    // read, or the last one read when no read is issued.
    assign mem_en_read = issue;
    assign mem_addr    = issue ? issue_addr : last_addr_q;

    assign w_data  = fifo_head[WORD_W-1:0];
    assign w_last  = fifo_head[WORD_W];
    assign w_valid = fifo_valid;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
